// File: rtl/l2_tag_pkg.sv
// Shared constants, FSM encoding and index-width helper for the L2 tag bank.
package l2_tag_pkg;

  localparam int L2_WAYS_DEF  = 4;
  localparam int L2_SETS_DEF  = 64;
  localparam int L2_WAY_W_DEF = $clog2(L2_WAYS_DEF);
  localparam int L2_SET_W_DEF = $clog2(L2_SETS_DEF);
  localparam int ST_INVALID   = 0;

  typedef enum logic [2:0] {
    IDLE,
    RSP,
    EVICT,
    FL_SCAN,
    FL_WB,
    FL_DONE
  } l2_fsm_e;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l2_tag_bank_p_if.sv
// Request / response / writeback / flush bundle between a cache controller and the tag bank.
interface l2_tag_bank_p_if
  import l2_tag_pkg::*;
#(
  parameter int TAG_W   = 20,
  parameter int SET_W   = L2_SET_W_DEF,
  parameter int WAY_W   = L2_WAY_W_DEF,
  parameter int STATE_W = 2
);
  logic               req_valid;
  logic               req_ready;
  logic               req_wr;
  logic [TAG_W-1:0]   req_tag;
  logic [SET_W-1:0]   req_set;
  logic [STATE_W-1:0] req_state;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_hit;
  logic [WAY_W-1:0]   rsp_way;
  logic [STATE_W-1:0] rsp_state;

  logic               wb_valid;
  logic               wb_ready;
  logic [TAG_W-1:0]   wb_tag;
  logic [SET_W-1:0]   wb_set;
  logic [STATE_W-1:0] wb_state;
  logic               wb_flush;

  logic               flush_valid;
  logic               flush_ready;
  logic               flush_done;

  modport slave (
    input  req_valid, req_wr, req_tag, req_set, req_state, rsp_ready, wb_ready, flush_valid,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_state,
           wb_valid, wb_tag, wb_set, wb_state, wb_flush, flush_ready, flush_done
  );

  modport master (
    output req_valid, req_wr, req_tag, req_set, req_state, rsp_ready, wb_ready, flush_valid,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_state,
           wb_valid, wb_tag, wb_set, wb_state, wb_flush, flush_ready, flush_done
  );
endinterface

// File: rtl/l2_tag_victim_sel.sv
// Replacement choice: lowest-index invalid way, else the set's round-robin pointer.
module l2_tag_victim_sel
  import l2_tag_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int WAY_W = idx_w(WAYS)
) (
  input  logic [WAYS-1:0]  i_vld,
  input  logic [WAY_W-1:0] i_ptr,
  output logic [WAY_W-1:0] o_way,
  output logic             o_inv
);

  always_comb begin
    o_way = i_ptr;
    o_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_vld[w]) begin
        o_way = WAY_W'(w);
        o_inv = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_tag_bank_p.sv
// Set-associative tag/state bank: lookup/install answered one cycle after accept, victim or flush writebacks
// stall on wb_ready, responses hold on rsp_ready; new requests are refused outside IDLE.
module l2_tag_bank_p
  import l2_tag_pkg::*;
#(
  parameter int WAYS    = 4,
  parameter int SETS    = 64,
  parameter int TAG_W   = 20,
  parameter int STATE_W = 2
) (
  input logic             clk,
  input logic             rst,
  l2_tag_bank_p_if.slave  bus
);

  localparam int WAY_W = idx_w(WAYS);
  localparam int SET_W = idx_w(SETS);
  localparam logic [WAY_W-1:0]   LAST_WAY = WAY_W'(WAYS - 1);
  localparam logic [SET_W-1:0]   LAST_SET = SET_W'(SETS - 1);
  localparam logic [STATE_W-1:0] ST_INV   = STATE_W'(ST_INVALID);

  logic [TAG_W-1:0]   r_tag [SETS][WAYS];
  logic [STATE_W-1:0] r_st  [SETS][WAYS];
  logic [WAY_W-1:0]   r_ptr [SETS];

  l2_fsm_e r_fsm, w_fsm_nxt;

  logic               r_rsp_hit;
  logic [WAY_W-1:0]   r_rsp_way;
  logic [STATE_W-1:0] r_rsp_state;
  logic [TAG_W-1:0]   r_wb_tag;
  logic [SET_W-1:0]   r_wb_set;
  logic [STATE_W-1:0] r_wb_state;
  logic               r_wb_flush;
  logic [TAG_W-1:0]   r_ins_tag;
  logic [SET_W-1:0]   r_ins_set;
  logic [WAY_W-1:0]   r_ins_way;
  logic [STATE_W-1:0] r_ins_state;
  logic [SET_W-1:0]   r_fl_set;
  logic [WAY_W-1:0]   r_fl_way;

  logic [WAYS-1:0]    w_vld_vec, w_hit_vec;
  logic               w_hit, w_vic_inv;
  logic [WAY_W-1:0]   w_hit_way, w_vic_way;
  logic               w_fire_req, w_fire_fl, w_fl_last, w_fl_cur_vld, w_fl_adv;
  logic               w_we, w_we_tag, w_ptr_inc, w_ptr_clr;
  logic [SET_W-1:0]   w_we_set;
  logic [WAY_W-1:0]   w_we_way;
  logic [STATE_W-1:0] w_we_st;
  logic [TAG_W-1:0]   w_we_tagv;

  // All ways of the requested set are compared in the accept cycle.
  always_comb begin
    w_vld_vec = '0;
    w_hit_vec = '0;
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_vld_vec[w] = (r_st[bus.req_set][w] != ST_INV);
      w_hit_vec[w] = w_vld_vec[w] && (r_tag[bus.req_set][w] == bus.req_tag);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hit_vec[w]) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  l2_tag_victim_sel #(.WAYS(WAYS), .WAY_W(WAY_W)) u_victim_sel (
    .i_vld (w_vld_vec),
    .i_ptr (r_ptr[bus.req_set]),
    .o_way (w_vic_way),
    .o_inv (w_vic_inv)
  );

  assign w_fire_fl    = (r_fsm == IDLE) && bus.flush_valid;
  assign w_fire_req   = (r_fsm == IDLE) && bus.req_valid && !bus.flush_valid;
  assign w_fl_last    = (r_fl_set == LAST_SET) && (r_fl_way == LAST_WAY);
  assign w_fl_cur_vld = (r_st[r_fl_set][r_fl_way] != ST_INV);
  assign w_fl_adv     = ((r_fsm == FL_SCAN) && !w_fl_cur_vld) || ((r_fsm == FL_WB) && bus.wb_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE: begin
        if (w_fire_fl)
          w_fsm_nxt = FL_SCAN;
        else if (w_fire_req)
          w_fsm_nxt = (bus.req_wr && !w_hit && !w_vic_inv) ? EVICT : RSP;
      end
      RSP:     if (bus.rsp_ready) w_fsm_nxt = IDLE;
      EVICT:   if (bus.wb_ready)  w_fsm_nxt = RSP;
      FL_SCAN: begin
        if (w_fl_cur_vld)   w_fsm_nxt = FL_WB;
        else if (w_fl_last) w_fsm_nxt = FL_DONE;
      end
      FL_WB:   if (bus.wb_ready) w_fsm_nxt = w_fl_last ? FL_DONE : FL_SCAN;
      FL_DONE: w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = (r_fsm == IDLE);
    bus.flush_ready = (r_fsm == IDLE);
    bus.rsp_valid   = (r_fsm == RSP);
    bus.wb_valid    = (r_fsm == EVICT) || (r_fsm == FL_WB);
    bus.flush_done  = (r_fsm == FL_DONE);
    w_we      = 1'b0;
    w_we_tag  = 1'b0;
    w_we_set  = bus.req_set;
    w_we_way  = w_hit_way;
    w_we_st   = bus.req_state;
    w_we_tagv = bus.req_tag;
    w_ptr_inc = 1'b0;
    w_ptr_clr = 1'b0;
    case (r_fsm)
      IDLE: begin
        if (w_fire_req && bus.req_wr) begin
          if (w_hit) begin
            w_we = 1'b1;
          end else if (w_vic_inv) begin
            w_we     = 1'b1;
            w_we_tag = 1'b1;
            w_we_way = w_vic_way;
          end
        end
      end
      EVICT: begin
        if (bus.wb_ready) begin
          w_we      = 1'b1;
          w_we_tag  = 1'b1;
          w_we_set  = r_ins_set;
          w_we_way  = r_ins_way;
          w_we_st   = r_ins_state;
          w_we_tagv = r_ins_tag;
          w_ptr_inc = 1'b1;
        end
      end
      FL_WB: begin
        if (bus.wb_ready) begin
          w_we     = 1'b1;
          w_we_set = r_fl_set;
          w_we_way = r_fl_way;
          w_we_st  = ST_INV;
        end
      end
      FL_DONE: w_ptr_clr = 1'b1;
      default: ;
    endcase
  end

  assign bus.rsp_hit   = r_rsp_hit;
  assign bus.rsp_way   = r_rsp_way;
  assign bus.rsp_state = r_rsp_state;
  assign bus.wb_tag    = r_wb_tag;
  assign bus.wb_set    = r_wb_set;
  assign bus.wb_state  = r_wb_state;
  assign bus.wb_flush  = r_wb_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_ptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_st[s][w] <= ST_INV;
      end
    end else begin
      if (w_we) r_st[w_we_set][w_we_way] <= w_we_st;
      if (w_ptr_clr) begin
        for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
      end else if (w_ptr_inc) begin
        r_ptr[w_we_set] <= r_ptr[w_we_set] + WAY_W'(1);
      end
    end
  end

  // Tags are meaningless while the state is invalid, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_we_tag) r_tag[w_we_set][w_we_way] <= w_we_tagv;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_hit   <= 1'b0;
      r_rsp_way   <= '0;
      r_rsp_state <= '0;
      r_wb_tag    <= '0;
      r_wb_set    <= '0;
      r_wb_state  <= '0;
      r_wb_flush  <= 1'b0;
      r_ins_tag   <= '0;
      r_ins_set   <= '0;
      r_ins_way   <= '0;
      r_ins_state <= '0;
      r_fl_set    <= '0;
      r_fl_way    <= '0;
    end else begin
      if (w_fire_req) begin
        r_rsp_hit   <= w_hit;
        r_rsp_way   <= (bus.req_wr && !w_hit) ? w_vic_way : w_hit_way;
        r_rsp_state <= bus.req_wr ? bus.req_state :
                       (w_hit ? r_st[bus.req_set][w_hit_way] : ST_INV);
        r_ins_tag   <= bus.req_tag;
        r_ins_set   <= bus.req_set;
        r_ins_way   <= w_vic_way;
        r_ins_state <= bus.req_state;
        r_wb_tag    <= r_tag[bus.req_set][w_vic_way];
        r_wb_set    <= bus.req_set;
        r_wb_state  <= r_st[bus.req_set][w_vic_way];
        r_wb_flush  <= 1'b0;
      end else if ((r_fsm == FL_SCAN) && w_fl_cur_vld) begin
        r_wb_tag    <= r_tag[r_fl_set][r_fl_way];
        r_wb_set    <= r_fl_set;
        r_wb_state  <= r_st[r_fl_set][r_fl_way];
        r_wb_flush  <= 1'b1;
      end
      if (w_fire_fl) begin
        r_fl_set <= '0;
        r_fl_way <= '0;
      end else if (w_fl_adv) begin
        r_fl_way <= r_fl_way + WAY_W'(1);
        if (r_fl_way == LAST_WAY) r_fl_set <= r_fl_set + SET_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_l2_tag_bank_p.sv
// Directed plus randomized checks of the tag bank against an array-based cache model.
module tb_l2_tag_bank_p;

  localparam int WAYS = 4, SETS = 8, TAG_W = 20, STATE_W = 2, WAY_W = 2, SET_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_tag_bank_p_if #(.TAG_W(TAG_W), .SET_W(SET_W), .WAY_W(WAY_W), .STATE_W(STATE_W)) bus ();

  l2_tag_bank_p #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .STATE_W(STATE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [TAG_W-1:0] m_tag [SETS][WAYS];
  int               m_st  [SETS][WAYS];
  int               m_ptr [SETS];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_st[s][w] = 0;
    end
  endtask

  // Cache semantics: hit updates in place, miss fills first empty way, else round-robin victim.
  task automatic model_req(input bit wr, input logic [TAG_W-1:0] tag, input int set, input int st,
                           output bit hit, output int way, output int rsp_st,
                           output bit evict, output logic [TAG_W-1:0] ev_tag, output int ev_st);
    int inv;
    hit = 0; way = 0; rsp_st = 0; evict = 0; ev_tag = '0; ev_st = 0; inv = -1;
    for (int w = 0; w < WAYS; w++)
      if (!hit && m_st[set][w] != 0 && m_tag[set][w] == tag) begin hit = 1; way = w; end
    if (!wr) begin
      rsp_st = hit ? m_st[set][way] : 0;
    end else begin
      if (hit) begin
        m_st[set][way] = st;
      end else begin
        for (int w = 0; w < WAYS; w++) if (inv < 0 && m_st[set][w] == 0) inv = w;
        if (inv >= 0) way = inv;
        else begin
          way = m_ptr[set];
          evict = 1; ev_tag = m_tag[set][way]; ev_st = m_st[set][way];
          m_ptr[set] = (m_ptr[set] + 1) % WAYS;
        end
        m_tag[set][way] = tag;
        m_st[set][way]  = st;
      end
      rsp_st = st;
    end
  endtask

  task automatic do_req(input bit wr, input logic [TAG_W-1:0] tag, input int set, input int st, input int hold);
    bit hit, evict;
    int way, est, evst;
    logic [TAG_W-1:0] evtag;
    logic [31:0] h0, w0, s0;
    model_req(wr, tag, set, st, hit, way, est, evict, evtag, evst);
    bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_tag = tag;
    bus.req_set = set[SET_W-1:0]; bus.req_state = st[STATE_W-1:0];
    chk("req_ready_idle", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    if (evict) begin
      chk("evict_wb_valid", bus.wb_valid, 1);
      chk("evict_wb_tag",   bus.wb_tag, evtag);
      chk("evict_wb_set",   bus.wb_set, set);
      chk("evict_wb_state", bus.wb_state, evst);
      chk("evict_wb_flush", bus.wb_flush, 0);
      chk("evict_no_rsp",   bus.rsp_valid, 0);
      bus.wb_ready = 1'b1;
      tick();
      bus.wb_ready = 1'b0;
    end else begin
      chk("no_wb", bus.wb_valid, 0);
    end
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_hit", bus.rsp_hit, hit);
    if (wr || hit) chk("rsp_way", bus.rsp_way, way);
    chk("rsp_state", bus.rsp_state, est);
    h0 = bus.rsp_hit; w0 = bus.rsp_way; s0 = bus.rsp_state;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_rsp_hit",   bus.rsp_hit, h0);
      chk("hold_rsp_way",   bus.rsp_way, w0);
      chk("hold_rsp_state", bus.rsp_state, s0);
      chk("hold_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("idle_after_rsp", bus.req_ready, 1);
  endtask

  task automatic do_flush(input int stall, input bit with_req, input logic [TAG_W-1:0] rtag, input int rset);
    logic [31:0] q_tag[$], q_set[$], q_st[$];
    int beats, exp_beats, cnt;
    bit early, done;
    beats = 0; cnt = 0; early = 0; done = 0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_st[s][w] != 0) begin
          q_tag.push_back(32'(m_tag[s][w])); q_set.push_back(s); q_st.push_back(m_st[s][w]);
        end
    exp_beats = q_tag.size();
    bus.flush_valid = 1'b1;
    if (with_req) begin
      bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_tag = rtag; bus.req_set = rset[SET_W-1:0];
    end
    chk("flush_ready", bus.flush_ready, 1);
    tick();
    bus.flush_valid = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      if (bus.req_ready) early = 1;
      if (bus.flush_done) begin
        done = 1;
      end else if (bus.wb_valid) begin
        chk("fl_wb_flush", bus.wb_flush, 1);
        if (q_tag.size() > 0) begin
          chk("fl_wb_tag",   bus.wb_tag, q_tag[0]);
          chk("fl_wb_set",   bus.wb_set, q_set[0]);
          chk("fl_wb_state", bus.wb_state, q_st[0]);
        end
        if (cnt < stall) begin
          cnt++;
          bus.wb_ready = 1'b0;
        end else begin
          bus.wb_ready = 1'b1;
          cnt = 0;
          beats++;
          if (q_tag.size() > 0) begin
            void'(q_tag.pop_front()); void'(q_set.pop_front()); void'(q_st.pop_front());
          end
        end
      end else begin
        bus.wb_ready = 1'b0;
      end
      if (!done) tick();
    end
    bus.wb_ready = 1'b0;
    chk("flush_done_seen", done, 1);
    chk("flush_beats", beats, exp_beats);
    chk("req_blocked_in_flush", early, 0);
    tick();
    chk("flush_done_pulse", bus.flush_done, 0);
    chk("idle_after_flush", bus.req_ready, 1);
    model_clear();
    if (with_req) begin
      bus.req_valid = 1'b0;
      do_req(0, rtag, rset, 0, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 0; bus.req_wr = 0; bus.req_tag = '0; bus.req_set = '0; bus.req_state = '0;
    bus.rsp_ready = 0; bus.wb_ready = 0; bus.flush_valid = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid",  bus.rsp_valid, 0);
    chk("rst_wb_valid",   bus.wb_valid, 0);
    chk("rst_flush_done", bus.flush_done, 0);
    rst = 1'b0;
    chk("post_rst_req_ready",   bus.req_ready, 1);
    chk("post_rst_flush_ready", bus.flush_ready, 1);

    do_req(1, TAG_W'('h12345), 3, 2, 0);
    do_req(0, TAG_W'('h12345), 3, 0, 0);

    // Fifth distinct install evicts way 0; sixth shows the pointer moved to way 1.
    for (int i = 0; i < 6; i++) do_req(1, TAG_W'('hA0000 + i), 5, 1 + (i % 3), 0);

    do_req(0, TAG_W'('h12345), 3, 0, 3);

    do_flush(0, 1, TAG_W'('h12345), 3);

    do_req(1, TAG_W'('h11111), 1, 1, 0);
    do_req(1, TAG_W'('h22222), 6, 2, 0);
    do_req(1, TAG_W'('h33333), 6, 3, 0);
    do_flush(2, 0, '0, 0);
    do_req(0, TAG_W'('h11111), 1, 0, 0);
    do_req(0, TAG_W'('h22222), 6, 0, 0);
    do_req(0, TAG_W'('h33333), 6, 0, 0);

    for (int i = 0; i < 80; i++)
      do_req(1'($urandom_range(0, 1)), TAG_W'('h100 + $urandom_range(0, 5)),
             $urandom_range(0, SETS - 1), $urandom_range(0, 3), $urandom_range(0, 2));
    do_flush($urandom_range(0, 3), 0, '0, 0);
    for (int t = 0; t < 6; t++) do_req(0, TAG_W'('h100 + t), $urandom_range(0, SETS - 1), 0, 0);

    do_req(1, TAG_W'('h55555), 2, 3, 0);
    do_req(1, TAG_W'('h66666), 7, 1, 0);
    bus.flush_valid = 1'b1;
    tick();
    bus.flush_valid = 1'b0;
    for (int c = 0; c < 100 && !bus.wb_valid; c++) tick();
    chk("wb_before_rst", bus.wb_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_flush_wb_valid",   bus.wb_valid, 0);
    chk("rst_mid_flush_flush_done", bus.flush_done, 0);
    chk("rst_mid_flush_rsp_valid",  bus.rsp_valid, 0);
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    chk("rel_req_ready",   bus.req_ready, 1);
    chk("rel_flush_ready", bus.flush_ready, 1);
    do_req(0, TAG_W'('h55555), 2, 0, 0);
    do_req(0, TAG_W'('h66666), 7, 0, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
